// File: rtl/CPU_pkg.sv
// Shared constants and decode helpers for the interrupt controller.
// Holds the register map and the maximum source count.
package CPU_pkg;

   localparam int INTC_NUM_SRC_MAX = 16;

   localparam logic [7:0] INTC_ADDR_PENDING   = 8'h00;
   localparam logic [7:0] INTC_ADDR_ENABLE    = 8'h04;
   localparam logic [7:0] INTC_ADDR_EDGE      = 8'h08;
   localparam logic [7:0] INTC_ADDR_THRESHOLD = 8'h0C;
   localparam logic [7:0] INTC_ADDR_CLAIM     = 8'h10;
   localparam logic [7:0] INTC_ADDR_PRIO_BASE = 8'h40;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_PENDING,
      REG_ENABLE,
      REG_EDGE,
      REG_THRESH,
      REG_CLAIM,
      REG_PRIO
   } intc_reg_e;

   function automatic intc_reg_e intc_decode(
      input logic [7:0] a,
      input int         nsrc
   );
      logic [5:0] w;
      intc_reg_e  r;
      w = a[7:2];
      r = REG_NONE;
      unique case (1'b1)
         (w == INTC_ADDR_PENDING[7:2]):   r = REG_PENDING;
         (w == INTC_ADDR_ENABLE[7:2]):    r = REG_ENABLE;
         (w == INTC_ADDR_EDGE[7:2]):      r = REG_EDGE;
         (w == INTC_ADDR_THRESHOLD[7:2]): r = REG_THRESH;
         (w == INTC_ADDR_CLAIM[7:2]):     r = REG_CLAIM;
         (w[5:4] == INTC_ADDR_PRIO_BASE[7:6]
            && int'(w[3:0]) < nsrc):      r = REG_PRIO;
         default:                         r = REG_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/int_controller_if.sv
// Valid/ready register bus between the CPU and the interrupt controller.
// Request and response channels each carry their own handshake.
interface int_controller_if;

   logic        valid_in;
   logic        ready_out;
   logic [7:0]  addr;
   logic        wena;
   logic [31:0] wdata;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] rdata;

   modport master (
      output valid_in,
      output addr,
      output wena,
      output wdata,
      output ready_in,
      input  ready_out,
      input  valid_out,
      input  rdata
   );

   modport slave (
      input  valid_in,
      input  addr,
      input  wena,
      input  wdata,
      input  ready_in,
      output ready_out,
      output valid_out,
      output rdata
   );

endinterface

// File: rtl/intc_gateway.sv
// Per-source gateway: edge detect, pending and in-service state.
// Level sources are gated by in_service; edge sources latch every rise.
module intc_gateway (
   input  logic clk,
   input  logic reset,
   input  logic src_q,
   input  logic edge_mode,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_service,
   output logic ip
);

   logic src_prev;
   logic edge_set;
   logic level_set;

   assign edge_set  = edge_mode && src_q && !src_prev;
   assign level_set = !edge_mode && src_q && !in_service;

   // Level requests count as pending one cycle early for arbitration.
   assign ip = pending || level_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         src_prev   <= 1'b0;
         pending    <= 1'b0;
         in_service <= 1'b0;
      end else begin
         src_prev   <= src_q;
         pending    <= edge_set
                    || (level_set && !claim)
                    || (pending && !claim);
         in_service <= claim || (in_service && !complete);
      end
   end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: register bus, per-source gateways, priority
// arbitration and the registered MEIP request.
module int_controller
   import CPU_pkg::*;
#(
   parameter int NUM_SRC = 16,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   int_controller_if.slave    bus,
   output logic               irq_int_controller
);

   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] edge_cfg;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;
   logic [NUM_SRC-1:0] ip;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] claim;
   logic [NUM_SRC-1:0] complete;
   logic [PRIO_W-1:0]  threshold;
   logic [PRIO_W-1:0]  prio [NUM_SRC];
   logic [PRIO_W-1:0]  best;
   logic [4:0]         win_id;
   logic [3:0]         prio_idx;
   logic [31:0]        rd_val;
   logic               accept;
   logic               claim_req;
   logic               cmp_req;
   intc_reg_e          sel;
   logic               unused_ok;

   assign bus.ready_out = !(bus.valid_out && !bus.ready_in);
   assign accept        = bus.valid_in && bus.ready_out;
   assign sel           = intc_decode(bus.addr, NUM_SRC);
   assign prio_idx      = bus.addr[5:2];
   assign claim_req     = accept && !bus.wena && (sel == REG_CLAIM);
   assign cmp_req       = accept && bus.wena && (sel == REG_CLAIM);
   assign unused_ok     = ^{bus.wdata[31:NUM_SRC], bus.addr[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q     <= '0;
         enable    <= '0;
         edge_cfg  <= '0;
         threshold <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            prio[i] <= '0;
         end
      end else begin
         src_q <= irq_src;
         if (accept && bus.wena) begin
            case (sel)
               REG_ENABLE: enable    <= bus.wdata[NUM_SRC-1:0];
               REG_EDGE:   edge_cfg  <= bus.wdata[NUM_SRC-1:0];
               REG_THRESH: threshold <= bus.wdata[PRIO_W-1:0];
               REG_PRIO:   prio[prio_idx] <= bus.wdata[PRIO_W-1:0];
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
      intc_gateway u_gw (
         .clk        (clk),
         .reset      (reset),
         .src_q      (src_q[g]),
         .edge_mode  (edge_cfg[g]),
         .claim      (claim[g]),
         .complete   (complete[g]),
         .pending    (pending[g]),
         .in_service (in_service[g]),
         .ip         (ip[g])
      );
   end

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         eligible[i] = ip[i] && enable[i] && !in_service[i]
                    && (prio[i] > threshold);
      end
   end

   // Strict compare keeps the lowest ID on equal priority.
   always_comb begin
      best   = '0;
      win_id = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible[i] && (prio[i] > best)) begin
            best   = prio[i];
            win_id = 5'(i + 1);
         end
      end
   end

   always_comb begin
      claim    = '0;
      complete = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         claim[i]    = claim_req && (win_id == 5'(i + 1));
         complete[i] = cmp_req && (bus.wdata[4:0] == 5'(i + 1));
      end
   end

   always_comb begin
      rd_val = '0;
      case (sel)
         REG_PENDING: rd_val = 32'(pending);
         REG_ENABLE:  rd_val = 32'(enable);
         REG_EDGE:    rd_val = 32'(edge_cfg);
         REG_THRESH:  rd_val = 32'(threshold);
         REG_CLAIM:   rd_val = 32'(win_id);
         REG_PRIO:    rd_val = 32'(prio[prio_idx]);
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.valid_out <= 1'b0;
         bus.rdata     <= '0;
      end else if (accept) begin
         bus.valid_out <= 1'b1;
         bus.rdata     <= bus.wena ? 32'd0 : rd_val;
      end else if (bus.ready_in) begin
         bus.valid_out <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_int_controller <= 1'b0;
      end else begin
         irq_int_controller <= |eligible;
      end
   end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller with a behavioural model.
// Directed scenarios followed by randomized bus/source traffic.
module tb_int_controller;

   localparam logic [7:0] A_PEND = 8'h00;
   localparam logic [7:0] A_EN   = 8'h04;
   localparam logic [7:0] A_EDGE = 8'h08;
   localparam logic [7:0] A_THR  = 8'h0C;
   localparam logic [7:0] A_CLM  = 8'h10;
   localparam logic [7:0] A_PRIO = 8'h40;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] irq_src;
   logic        irq;
   int          total = 0;
   int          bad = 0;

   logic [15:0] m_pend, m_isv, m_en, m_edge, m_src;
   int          m_thr;
   int          m_prio [16];

   int_controller_if bif();

   int_controller #(.NUM_SRC(16), .PRIO_W(3)) dut (
      .clk                (clk),
      .reset              (reset),
      .irq_src            (irq_src),
      .bus                (bif.slave),
      .irq_int_controller (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic logic m_elig(input int i);
      return m_pend[i] && m_en[i] && !m_isv[i] && (m_prio[i] > m_thr);
   endfunction

   function automatic int m_win();
      int top = 0;
      for (int i = 0; i < 16; i++)
         if (m_elig(i) && m_prio[i] > top) top = m_prio[i];
      if (top == 0) return 0;
      for (int i = 0; i < 16; i++)
         if (m_elig(i) && m_prio[i] == top) return i + 1;
      return 0;
   endfunction

   function automatic void m_settle();
      for (int i = 0; i < 16; i++)
         if (!m_edge[i] && m_src[i] && !m_isv[i]) m_pend[i] = 1'b1;
   endfunction

   function automatic int m_claim();
      int id = m_win();
      if (id != 0) begin
         m_pend[id-1] = 1'b0;
         m_isv[id-1]  = 1'b1;
      end
      return id;
   endfunction

   function automatic void m_complete(input int id);
      if (id >= 1 && id <= 16 && m_isv[id-1]) begin
         m_isv[id-1] = 1'b0;
         m_settle();
      end
   endfunction

   function automatic void m_clear();
      m_pend = '0; m_isv = '0; m_en = '0; m_edge = '0; m_src = '0;
      m_thr = 0;
      for (int i = 0; i < 16; i++) m_prio[i] = 0;
   endfunction

   task automatic bus(input logic [7:0] a, input logic we,
                      input logic [31:0] wd, output logic [31:0] rd);
      int n = 0;
      @(negedge clk);
      bif.valid_in = 1'b1;
      bif.addr     = a;
      bif.wena     = we;
      bif.wdata    = wd;
      while (bif.ready_out !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bif.valid_in = 1'b0;
      rd = bif.rdata;
      total++;
      if (bif.valid_out !== 1'b1 || n >= 50) begin
         bad++;
         $display("FAIL bus_resp addr=%h valid_out=%b want 1 wait=%0d",
                  a, bif.valid_out, n);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      logic [31:0] x;
      bus(a, 1'b1, d, x);
   endtask

   task automatic rdreg(input logic [7:0] a, output logic [31:0] d);
      bus(a, 1'b0, 32'd0, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      bif.valid_in = 1'b0;
      bif.ready_in = 1'b1;
      irq_src      = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_clear();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [7:0]  a;
      do_reset();
      total++;
      if (bif.valid_out !== 1'b0 || bif.ready_out !== 1'b1
          || irq !== 1'b0 || bif.rdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_outs vo=%b ro=%b irq=%b rd=%h want 0/1/0/0",
                  bif.valid_out, bif.ready_out, irq, bif.rdata);
      end
      for (int i = 0; i < 21; i++) begin
         a = (i < 5) ? 8'(i * 4) : 8'(8'h40 + (i - 5) * 4);
         rdreg(a, d);
         total++;
         if (d !== 32'd0) begin
            bad++;
            $display("FAIL reset_reg addr=%h got=%h want 0", a, d);
         end
      end
      bus(A_EN, 1'b1, 32'hFFFF_FFFF, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL wr_rdata got=%h want 0", d);
      end
      wr(A_PEND, 32'hFFFF_FFFF);
      wr(8'h20, 32'hFFFF_FFFF);
      wr(A_THR, 32'hFF);
      rdreg(A_EN, d);
      total++;
      if (d !== 32'h0000_FFFF) begin
         bad++;
         $display("FAIL en_width got=%h want 0000ffff", d);
      end
      rdreg(A_PEND, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL pend_ro got=%h want 0", d);
      end
      rdreg(8'h20, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL unmapped got=%h want 0", d);
      end
      rdreg(A_THR, d);
      total++;
      if (d !== 32'd7) begin
         bad++;
         $display("FAIL thr_width got=%h want 7", d);
      end
   endtask

   task automatic test_level();
      logic [31:0] d;
      do_reset();
      wr(A_PRIO + 8'd8, 32'd5);
      wr(A_EN, 32'h4);
      @(negedge clk);
      irq_src[2] = 1'b1;
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL lvl_irq_c1 got=%b want 0", irq);
      end
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL lvl_irq_c2 got=%b want 1", irq);
      end
      rdreg(A_CLM, d);
      total++;
      if (d !== 32'd3) begin
         bad++;
         $display("FAIL lvl_claim got=%0d want 3", d);
      end
      repeat (2) @(negedge clk);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL lvl_irq_svc got=%b want 0", irq);
      end
      wr(A_CLM, 32'd3);
      repeat (2) @(negedge clk);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL lvl_irq_ret got=%b want 1", irq);
      end
      rdreg(A_PEND, d);
      total++;
      if (d !== 32'h4) begin
         bad++;
         $display("FAIL lvl_pend got=%h want 4", d);
      end
   endtask

   task automatic test_tie();
      logic [31:0] d;
      int exp_ids [4] = '{2, 5, 0, 2};
      do_reset();
      wr(A_PRIO + 8'd4, 32'd4);
      wr(A_PRIO + 8'd16, 32'd4);
      wr(A_EN, 32'h12);
      @(negedge clk);
      irq_src = 16'h0012;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            wr(A_CLM, 32'd0);
            wr(A_CLM, 32'd20);
            wr(A_CLM, 32'hFFFF_FFE2);
         end
         rdreg(A_CLM, d);
         total++;
         if (d !== 32'(exp_ids[k])) begin
            bad++;
            $display("FAIL tie_claim%0d got=%0d want %0d", k, d, exp_ids[k]);
         end
      end
   endtask

   task automatic test_threshold();
      do_reset();
      wr(A_THR, 32'd4);
      wr(A_PRIO, 32'd4);
      wr(A_EN, 32'h1);
      @(negedge clk);
      irq_src[0] = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL thr_eq got=%b want 0", irq);
      end
      wr(A_PRIO, 32'd5);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL thr_c1 got=%b want 0", irq);
      end
      @(posedge clk); #1;
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL thr_c2 got=%b want 1", irq);
      end
   endtask

   task automatic test_edge();
      logic [31:0] d;
      do_reset();
      wr(A_EDGE, 32'h40);
      wr(A_PRIO + 8'd24, 32'd3);
      wr(A_EN, 32'h40);
      for (int p = 0; p < 2; p++) begin
         @(negedge clk);
         irq_src[6] = 1'b1;
         @(negedge clk);
         irq_src[6] = 1'b0;
         repeat (4) @(negedge clk);
         total++;
         if (irq !== (p == 0)) begin
            bad++;
            $display("FAIL edge_irq%0d got=%b want %b", p, irq, p == 0);
         end
         if (p == 0) begin
            rdreg(A_CLM, d);
            total++;
            if (d !== 32'd7) begin
               bad++;
               $display("FAIL edge_claim got=%0d want 7", d);
            end
         end
      end
      rdreg(A_PEND, d);
      total++;
      if (d !== 32'h40) begin
         bad++;
         $display("FAIL edge_pend got=%h want 40", d);
      end
      wr(A_CLM, 32'd7);
      repeat (3) @(negedge clk);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL edge_irq_cmp got=%b want 1", irq);
      end
      rdreg(A_CLM, d);
      total++;
      if (d !== 32'd7) begin
         bad++;
         $display("FAIL edge_claim2 got=%0d want 7", d);
      end
   endtask

   task automatic test_stall();
      do_reset();
      wr(A_EN, 32'h1234);
      wr(A_THR, 32'd5);
      repeat (2) @(negedge clk);
      bif.ready_in = 1'b0;
      bif.valid_in = 1'b1;
      bif.addr     = A_EN;
      bif.wena     = 1'b0;
      bif.wdata    = '0;
      @(posedge clk); #1;
      bif.addr = A_THR;
      total++;
      if (bif.valid_out !== 1'b1 || bif.rdata !== 32'h1234) begin
         bad++;
         $display("FAIL stall_first vo=%b rd=%h want 1/1234",
                  bif.valid_out, bif.rdata);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         total++;
         if (bif.valid_out !== 1'b1 || bif.rdata !== 32'h1234
             || bif.ready_out !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d vo=%b rd=%h ro=%b want 1/1234/0",
                     k, bif.valid_out, bif.rdata, bif.ready_out);
         end
      end
      @(negedge clk);
      bif.ready_in = 1'b1;
      @(posedge clk); #1;
      bif.valid_in = 1'b0;
      total++;
      if (bif.valid_out !== 1'b1 || bif.rdata !== 32'd5) begin
         bad++;
         $display("FAIL stall_second vo=%b rd=%h want 1/5",
                  bif.valid_out, bif.rdata);
      end
      @(posedge clk); #1;
      total++;
      if (bif.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL stall_drain vo=%b want 0", bif.valid_out);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bif.valid_in = 1'b1;
         bif.addr     = 8'(8'h40 + (k % 4) * 4);
         bif.wena     = (k < 4);
         bif.wdata    = 32'(k + 1);
         @(posedge clk); #1;
         total++;
         if (bif.valid_out !== 1'b1
             || (k >= 4 && bif.rdata !== 32'(k - 3))) begin
            bad++;
            $display("FAIL b2b%0d vo=%b rd=%h want 1/%0d",
                     k, bif.valid_out, bif.rdata, (k >= 4) ? k - 3 : 0);
         end
      end
      bif.valid_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      do_reset();
      wr(A_EN, 32'hFFFF);
      wr(A_THR, 32'd3);
      repeat (2) @(negedge clk);
      bif.ready_in = 1'b0;
      bif.valid_in = 1'b1;
      bif.addr     = A_EN;
      bif.wena     = 1'b0;
      @(posedge clk); #1;
      bif.valid_in = 1'b0;
      total++;
      if (bif.valid_out !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_acc vo=%b want 1", bif.valid_out);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bif.valid_out !== 1'b0 || bif.rdata !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_drop vo=%b rd=%h want 0/0",
                  bif.valid_out, bif.rdata);
      end
      @(negedge clk);
      reset = 1'b0;
      bif.ready_in = 1'b1;
      m_clear();
      repeat (3) @(negedge clk);
      total++;
      if (bif.valid_out !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_idle vo=%b want 0", bif.valid_out);
      end
      rdreg(A_EN, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_en got=%h want 0", d);
      end
      rdreg(A_THR, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL rstmid_thr got=%h want 0", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, r, wd;
      logic [15:0] v;
      int op, k, id, exp;
      do_reset();
      wr(A_EN, 32'hFFFF);
      m_en = 16'hFFFF;
      for (int i = 0; i < 16; i++) begin
         m_prio[i] = $urandom_range(1, 7);
         wr(8'(8'h40 + i * 4), 32'(m_prio[i]));
      end
      for (int it = 0; it < 150; it++) begin
         op = $urandom_range(0, 7);
         r  = $urandom;
         case (op)
            0: begin
               v = r[15:0];
               for (int i = 0; i < 16; i++)
                  if (m_edge[i] && v[i] && !m_src[i]) m_pend[i] = 1'b1;
               m_src = v;
               m_settle();
               @(negedge clk);
               irq_src = v;
               repeat (3) @(negedge clk);
            end
            1: begin
               wr(A_EN, r);
               m_en = r[15:0];
               rdreg(A_EN, d);
               total++;
               if (d !== {16'd0, m_en}) begin
                  bad++;
                  $display("FAIL rnd_en got=%h want %h", d, m_en);
               end
            end
            2: begin
               wr(A_EDGE, r);
               m_edge = r[15:0];
               m_settle();
            end
            3: begin
               wr(A_THR, r);
               m_thr = int'(r[2:0]) % 4;
               wr(A_THR, 32'(m_thr));
            end
            4: begin
               k = $urandom_range(0, 15);
               wr(8'(8'h40 + k * 4), r);
               m_prio[k] = int'(r[2:0]);
            end
            5: begin
               exp = m_claim();
               rdreg(A_CLM, d);
               total++;
               if (d !== 32'(exp)) begin
                  bad++;
                  $display("FAIL rnd_claim got=%0d want %0d", d, exp);
               end
            end
            6: begin
               id = $urandom_range(0, 31);
               if (r[0] && m_isv != 0) begin
                  k = $urandom_range(0, 15);
                  while (!m_isv[k]) k = (k + 1) % 16;
                  id = k + 1;
               end
               wd = {r[31:5], 5'(id)};
               wr(A_CLM, wd);
               m_complete(id);
            end
            default: begin
               rdreg(A_PEND, d);
               total++;
               if (d !== {16'd0, m_pend}) begin
                  bad++;
                  $display("FAIL rnd_pend got=%h want %h", d, m_pend);
               end
            end
         endcase
         repeat (3) @(negedge clk);
         total++;
         if (irq !== (m_win() != 0)) begin
            bad++;
            $display("FAIL rnd_irq it=%0d got=%b want %b",
                     it, irq, m_win() != 0);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      irq_src      = '0;
      bif.valid_in = 1'b0;
      bif.addr     = '0;
      bif.wena     = 1'b0;
      bif.wdata    = '0;
      bif.ready_in = 1'b1;
      m_clear();
      test_reset();
      test_level();
      test_tie();
      test_threshold();
      test_edge();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
